data_mem_ctrl: RTL and testbench

- Load/store controller that sits directly downstream of rv32i_core and replaces the bare data memory path.
- Accepts one data access at a time from the core: store, or load with byte/halfword/word size.
- Handles byte-lane write enables, load sign/zero extension and a programmable number of wait states.
- Returns completion through a ready handshake so the core can stall until the access finishes.

---
 rtl/data_mem_ctrl.sv | 166 ++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: load/store controller with byte lanes and wait states.
// Optional misaligned-access trap: define DMEM_MISALIGN_TRAP_EN.
module data_mem_ctrl #(
  parameter int MEM_WORDS   = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [6:0]  addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  size,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS,
    DONE
  } state_t;

  localparam logic [3:0] WAIT_INIT =
    (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t      state_q;
  state_t      state_d;
  logic [3:0]  cnt_q;
  logic [31:0] mem [MEM_WORDS];

  logic [4:0]  idx;
  logic        is_byte;
  logic        is_half;
  logic        trap;
  logic [3:0]  be;
  logic [31:0] wlane;
  logic [31:0] word;
  logic [7:0]  bsel;
  logic [15:0] hsel;
  logic [31:0] ld_val;

  assign idx     = addr[6:2];
  assign is_byte = (size[1:0] == 2'b00);
  assign is_half = (size[1:0] == 2'b01);

`ifdef DMEM_MISALIGN_TRAP_EN
  assign trap = (is_half && addr[0]) ||
                (size[1] && (addr[1:0] != 2'b00));
`else
  assign trap = 1'b0;
`endif

  // Byte-lane enables and lane-replicated store data
  always_comb begin
    be    = 4'b1111;
    wlane = wdata;
    unique case (1'b1)
      is_byte: begin
        be    = 4'b0001 << addr[1:0];
        wlane = {4{wdata[7:0]}};
      end
      is_half: begin
        be    = addr[1] ? 4'b1100 : 4'b0011;
        wlane = {2{wdata[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wlane = wdata;
      end
    endcase
  end

  // Load lane selection and sign/zero extension
  always_comb begin
    word   = mem[idx];
    bsel   = 8'(word >> {addr[1:0], 3'b000});
    hsel   = addr[1] ? word[31:16] : word[15:0];
    ld_val = word;
    unique case (1'b1)
      is_byte: ld_val = size[2] ? {24'd0, bsel}
                                : {{24{bsel[7]}}, bsel};
      is_half: ld_val = size[2] ? {16'd0, hsel}
                                : {{16{hsel[15]}}, hsel};
      default: ld_val = word;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (trap)                 state_d = DONE;
          else if (WAIT_CYCLES > 0) state_d = WAIT;
          else                      state_d = ACCESS;
        end
      end
      WAIT:    if (cnt_q == 4'd0) state_d = ACCESS;
      ACCESS:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Wait counter and registered load result
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 4'd0;
      rdata <= 32'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req) begin
            cnt_q <= WAIT_INIT;
            if (trap) rdata <= 32'd0;
          end
        end
        WAIT: begin
          if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
        end
        ACCESS: begin
          if (!we) rdata <= ld_val;
        end
        default: ;
      endcase
    end
  end

  // Store commits only on an ACCESS edge without reset
  always_ff @(posedge clk) begin
    if (!rst && state_q == ACCESS && we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][i*8 +: 8] <= wlane[i*8 +: 8];
      end
    end
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  logic err_q;

  // Error flag lives only for the DONE cycle of a trapped access
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= (state_q == IDLE) && req && trap;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign ready = (state_q == DONE);
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: random load/store traffic against a byte-array model.
// Also covers reset abandonment and back-to-back spacing with no waits.
module tb_data_mem_ctrl;

  localparam int W = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, we;
  logic [6:0]  addr;
  logic [31:0] wdata;
  logic [2:0]  size;
  logic [31:0] rdata;
  logic        ready, busy, err;

  logic        q_req, q_we;
  logic [6:0]  q_addr;
  logic [31:0] q_wdata;
  logic [2:0]  q_size;
  logic [31:0] q_rdata;
  logic        q_ready, q_busy, q_err;

  always #5 clk = ~clk;

  data_mem_ctrl #(.MEM_WORDS(32), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we),
    .addr(addr), .wdata(wdata), .size(size),
    .rdata(rdata), .ready(ready), .busy(busy), .err(err)
  );

  data_mem_ctrl #(.MEM_WORDS(32), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req(q_req), .we(q_we),
    .addr(q_addr), .wdata(q_wdata), .size(q_size),
    .rdata(q_rdata), .ready(q_ready), .busy(q_busy), .err(q_err)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          cmp = 0;
  int          mism = 0;
  logic [7:0]  mb [128];
  logic [31:0] m_rdata = 32'd0;
  logic [31:0] exp_rd = 32'd0;
  logic        exp_err = 1'b0;
  int          start_c = -100;
  int          ready_at = -100;
  bit          chk_en = 0;
  int          ready_cnt = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      mism++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  function automatic int nbytes(input logic [2:0] s);
    case (s)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic bit is_trap(input logic [6:0] a,
                                 input logic [2:0] s);
`ifdef DMEM_MISALIGN_TRAP_EN
    int n = nbytes(s);
    return (n > 1) && ((int'(a) % n) != 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] model_load(input logic [6:0] a,
                                             input logic [2:0] s);
    int n = nbytes(s);
    int base = int'(a) / n * n;
    logic [31:0] v = 32'd0;
    for (int i = 0; i < n; i++)
      v = v | (32'(mb[base + i]) << (8 * i));
    if (n < 4 && !s[2] && v[8*n-1])
      v = v | ~((32'h1 << (8 * n)) - 32'h1);
    return v;
  endfunction

  task automatic model_store(input logic [6:0] a, input logic [31:0] d,
                             input logic [2:0] s);
    int n = nbytes(s);
    int base = int'(a) / n * n;
    for (int i = 0; i < n; i++) mb[base + i] = d[8*i +: 8];
  endtask

  task automatic mon();
    forever begin
      @(negedge clk);
      if (ready) ready_cnt++;
      if (chk_en) begin
        check("ready", 32'(ready), 32'(cyc == ready_at));
        check("busy", 32'(busy),
              32'(cyc > start_c && cyc <= ready_at));
        if (cyc == ready_at) begin
          check("rdata", rdata, exp_rd);
          check("err", 32'(err), 32'(exp_err));
        end else begin
          check("err_idle", 32'(err), 32'd0);
        end
      end
    end
  endtask

  task automatic access(input logic w, input logic [6:0] a,
                        input logic [31:0] d, input logic [2:0] s,
                        output logic [31:0] got, output int lat);
    bit t = is_trap(a, s);
    if (t)       m_rdata = 32'd0;
    else if (!w) m_rdata = model_load(a, s);
    else         model_store(a, d, s);
    exp_rd   = m_rdata;
    exp_err  = t;
    start_c  = cyc;
    ready_at = cyc + (t ? 1 : W + 2);
    req = 1'b1; we = w; addr = a; wdata = d; size = s;
    got = 32'd0;
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ready) begin
        got = rdata;
        lat = cyc - start_c;
        break;
      end
    end
    if (lat < 0) begin
      cmp++;
      mism++;
      $display("FAIL timeout: no ready for addr %h, expected within 20",
               a);
    end
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  logic [31:0] g, old;
  int          l, rc, n, idle;
  int          rt [2];

  initial begin
    rst = 1'b1;
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0; size = '0;
    q_req = 1'b0; q_we = 1'b0; q_addr = '0; q_wdata = '0; q_size = '0;
    fork mon(); join_none
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rdata", rdata, 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_rdata = 32'd0;
    chk_en = 1;

    for (int i = 0; i < 32; i++)
      access(1'b1, 7'(i * 4), $urandom, 3'b010, g, l);

    access(1'b1, 7'h04, 32'hDEADBEEF, 3'b010, g, l);
    check("sw_lat", 32'(l), 32'd3);
    access(1'b0, 7'h04, 32'd0, 3'b010, g, l);
    check("lw_04", g, 32'hDEADBEEF);
    check("lw_lat", 32'(l), 32'd3);

    access(1'b1, 7'h08, 32'h11223344, 3'b010, g, l);
    access(1'b1, 7'h09, 32'h000000A5, 3'b000, g, l);
    access(1'b0, 7'h08, 32'd0, 3'b010, g, l);
    check("sb_lw", g, 32'h1122A544);
    access(1'b0, 7'h09, 32'd0, 3'b000, g, l);
    check("lb", g, 32'hFFFFFFA5);
    access(1'b0, 7'h09, 32'd0, 3'b100, g, l);
    check("lbu", g, 32'h000000A5);

    access(1'b1, 7'h10, 32'h12345678, 3'b010, g, l);
    access(1'b1, 7'h12, 32'h00008001, 3'b001, g, l);
    access(1'b0, 7'h12, 32'd0, 3'b001, g, l);
    check("lh", g, 32'hFFFF8001);
    access(1'b0, 7'h12, 32'd0, 3'b101, g, l);
    check("lhu", g, 32'h00008001);
    access(1'b0, 7'h10, 32'd0, 3'b010, g, l);
    check("sh_lw", g, 32'h80015678);

`ifdef DMEM_MISALIGN_TRAP_EN
    access(1'b0, 7'h05, 32'd0, 3'b010, g, l);
    check("trap_rdata", g, 32'd0);
    check("trap_lat", 32'(l), 32'd1);
    access(1'b1, 7'h06, 32'h0BADF00D, 3'b010, g, l);
    access(1'b0, 7'h04, 32'd0, 3'b010, g, l);
    check("trap_nowrite", g, 32'hDEADBEEF);
`endif

    repeat (250) begin
      access(1'(($urandom_range(0, 1))),
             7'($urandom_range(0, 127)), $urandom,
             3'($urandom_range(0, 7)), g, l);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    access(1'b0, 7'h04, 32'd0, 3'b010, g, l);
    old = model_load(7'h20, 3'b010);
    chk_en = 0;
    rc = ready_cnt;
    req = 1'b1; we = 1'b1; addr = 7'h20; wdata = ~old; size = 3'b010;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    req = 1'b0;
    @(negedge clk);
    check("rstw_busy", 32'(busy), 32'd0);
    check("rstw_rdata", rdata, 32'd0);
    req = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    req = 1'b0;
    @(negedge clk);
    check("rsta_busy", 32'(busy), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    check("rst_noready", 32'(ready_cnt), 32'(rc));
    m_rdata = 32'd0;
    chk_en = 1;
    access(1'b0, 7'h20, 32'd0, 3'b010, g, l);
    check("rst_nowrite", g, old);
    chk_en = 0;

    q_we = 1'b1; q_addr = 7'h10; q_wdata = 32'hA5A50F0F; q_size = 3'b010;
    start_c = cyc;
    q_req = 1'b1;
    n = 0;
    idle = 0;
    rt[0] = 0;
    rt[1] = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (q_ready) begin
        rt[n] = cyc;
        n++;
        if (n == 2) break;
      end else if (n == 1 && !q_busy) begin
        idle++;
      end
    end
    @(posedge clk); #1;
    q_req = 1'b0;
    check("b2b_pulses", 32'(n), 32'd2);
    check("b2b_lat", 32'(rt[0] - start_c), 32'd2);
    check("b2b_space", 32'(rt[1] - rt[0]), 32'd3);
    check("b2b_idle", 32'(idle), 32'd1);

    @(posedge clk); #1;
    q_we = 1'b0;
    q_req = 1'b1;
    g = 32'd0;
    l = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (q_ready) begin
        g = q_rdata;
        l = i;
        break;
      end
    end
    @(posedge clk); #1;
    q_req = 1'b0;
    if (l < 0) $display("FAIL w0_timeout: no ready, expected one");
    check("w0_lw", g, 32'hA5A50F0F);
    check("w0_err", 32'(q_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
    $finish;
  end

endmodule
